lsu_mem_stage: RTL and testbench

Load/store unit sitting directly upstream of the write-back select stage. It turns core load/store requests into a single-beat word-addressed ready/valid data-bus transaction. On loads it extracts and sign/zero-extends the addressed byte, halfword or word, and presents the result as data_out to the write-back mux. It stalls the core while a transaction is outstanding and reports misaligned, illegal or timed-out accesses.

---
 rtl/lsu_mem_stage.sv | 197 +++++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_mem_stage
//  Purpose  : Single-beat load/store bus master with load extension, store
//             lane replication, stall generation and fault reporting.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_mem_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    output logic [31:0] data_out,
    output logic        stall,
    output logic        fault
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_last = CNT_W'(TIMEOUT - 1);

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_is_load;
    logic [2:0]        r_funct3;
    logic [1:0]        r_off;
    logic              r_we;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic [31:0]       r_data_out;
    logic              r_fault;

    logic              w_req;
    logic              w_f3_ok;
    logic              w_misaligned;
    logic              w_ok;
    logic              w_timeout;
    logic [31:0]       w_wdata;
    logic [3:0]        w_wstrb;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_ext;

    assign w_req     = mem_read | mem_write;
    assign w_timeout = (r_cnt == c_last);

    // Request legality and alignment
    always_comb begin
        w_f3_ok = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
            3'b100, 3'b101:         w_f3_ok = mem_read & ~mem_write;
            default:                w_f3_ok = 1'b0;
        endcase
        w_misaligned = 1'b0;
        case (funct3[1:0])
            2'b01:   w_misaligned = addr[0];
            2'b10:   w_misaligned = (addr[1:0] != 2'b00);
            default: w_misaligned = 1'b0;
        endcase
        w_ok = w_req & ~(mem_read & mem_write) & w_f3_ok & ~w_misaligned;
    end

    // Store lane replication and byte enables
    always_comb begin
        w_wdata = store_data;
        w_wstrb = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                w_wdata = {4{store_data[7:0]}};
                w_wstrb = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                w_wdata = {2{store_data[15:0]}};
                w_wstrb = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_wdata = store_data;
                w_wstrb = 4'b1111;
            end
        endcase
    end

    // Load lane extraction from the returned word
    always_comb begin
        w_byte = bus_rdata[7:0];
        case (r_off)
            2'd0: w_byte = bus_rdata[7:0];
            2'd1: w_byte = bus_rdata[15:8];
            2'd2: w_byte = bus_rdata[23:16];
            2'd3: w_byte = bus_rdata[31:24];
            default: w_byte = bus_rdata[7:0];
        endcase
        w_half = r_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (r_funct3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_ext = {24'h0, w_byte};
            3'b101:  w_ext = {16'h0, w_half};
            default: w_ext = bus_rdata;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_req) w_next = w_ok ? S_WAIT : S_DONE;
            S_WAIT:  if (bus_ready || w_timeout) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_is_load  <= 1'b0;
            r_funct3   <= 3'b000;
            r_off      <= 2'b00;
            r_we       <= 1'b0;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_wstrb    <= 4'b0000;
            r_data_out <= 32'h0;
            r_fault    <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    r_fault <= 1'b0;
                    r_cnt   <= '0;
                    if (w_req) begin
                        if (w_ok) begin
                            r_is_load <= mem_read;
                            r_funct3  <= funct3;
                            r_off     <= addr[1:0];
                            r_we      <= mem_write;
                            r_addr    <= {addr[31:2], 2'b00};
                            r_wdata   <= w_wdata;
                            r_wstrb   <= mem_write ? w_wstrb : 4'b0000;
                        end else begin
                            r_fault <= 1'b1;
                            if (mem_read) r_data_out <= 32'h0;
                        end
                    end
                end
                S_WAIT: begin
                    // A beat completing on the final allowed cycle is not a timeout
                    if (bus_ready) begin
                        if (r_is_load) r_data_out <= w_ext;
                    end else if (w_timeout) begin
                        r_fault <= 1'b1;
                        if (r_is_load) r_data_out <= 32'h0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_fault <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus_req   = (r_state == S_WAIT);
    assign bus_we    = r_we;
    assign bus_addr  = r_addr;
    assign bus_wdata = r_wdata;
    assign bus_wstrb = r_wstrb;
    assign data_out  = r_data_out;
    assign fault     = r_fault;
    // Gated by rst_n so a held request cannot keep the core stalled in reset
    assign stall     = rst_n & (((r_state == S_IDLE) & w_req) | (r_state == S_WAIT));

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_mem_stage
//  Purpose  : Directed scoreboard bench for lsu_mem_stage.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ready = 1'b0;
    logic [31:0] bus_rdata = 32'h0;
    logic [31:0] data_out;
    logic        stall;
    logic        fault;

    lsu_mem_stage #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .store_data(store_data),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_ready(bus_ready),
        .bus_rdata(bus_rdata), .data_out(data_out), .stall(stall), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fault;
        logic [31:0] data;
        int          stall_n;
        int          req_n;
        logic [31:0] baddr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   ready_at = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic f, input logic [31:0] d, input int s, input int r,
                                input logic [31:0] ba, input logic w, input logic [3:0] st,
                                input logic [31:0] wd);
        exp_t e;
        e.fault = f; e.data = d; e.stall_n = s; e.req_n = r;
        e.baddr = ba; e.we = w; e.wstrb = st; e.wdata = wd;
        return e;
    endfunction

    // Bus slave: raise bus_ready on the ready_at-th cycle of bus_req (0 = never)
    int wcnt = 0;
    always @(negedge clk) begin
        if (!bus_req) begin
            wcnt = 0;
            bus_ready = 1'b0;
        end else begin
            wcnt++;
            bus_ready = (ready_at != 0) && (wcnt == ready_at);
        end
    end

    // Monitor: a completion is the falling edge of stall outside reset
    logic        prev_stall = 1'b0;
    int          stall_cnt = 0;
    int          req_cnt = 0;
    int          fault_cnt = 0;
    logic        bus_seen = 1'b0;
    logic [31:0] cap_addr, cap_wdata;
    logic        cap_we;
    logic [3:0]  cap_wstrb;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0; stall_cnt = 0; req_cnt = 0; fault_cnt = 0; bus_seen = 1'b0;
        end else begin
            if (stall) stall_cnt++;
            if (fault) fault_cnt++;
            if (bus_req) begin
                req_cnt++;
                if (!bus_seen) begin
                    cap_addr = bus_addr; cap_we = bus_we; cap_wstrb = bus_wstrb; cap_wdata = bus_wdata;
                    bus_seen = 1'b1;
                end else begin
                    chk("bus_addr_stable", bus_addr, cap_addr);
                    chk("bus_wdata_stable", bus_wdata, cap_wdata);
                end
            end
            if (prev_stall && !stall) begin
                if (q.size() == 0) begin
                    chk("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("fault_in_done", 32'(fault), 32'(e.fault));
                    chk("fault_cycles", 32'(fault_cnt), 32'(e.fault));
                    chk("data_out", data_out, e.data);
                    chk("stall_cycles", 32'(stall_cnt), 32'(e.stall_n));
                    chk("bus_req_cycles", 32'(req_cnt), 32'(e.req_n));
                    if (e.req_n != 0) begin
                        chk("bus_addr", cap_addr, e.baddr);
                        chk("bus_we", 32'(cap_we), 32'(e.we));
                        chk("bus_wstrb", 32'(cap_wstrb), 32'(e.wstrb));
                        if (e.we) chk("bus_wdata", cap_wdata, e.wdata);
                    end
                end
                stall_cnt = 0; req_cnt = 0; fault_cnt = 0; bus_seen = 1'b0;
            end
            prev_stall = stall;
        end
    end

    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] rdat, input int rdy, input exp_t e);
        int n;
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
        bus_rdata = rdat; ready_at = rdy;
        q.push_back(e);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (stall && n < 40);
        if (n >= 40) chk("completion_timeout", 32'd1, 32'd0);
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_we", 32'(bus_we), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        chk("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
        chk("rst_data_out", data_out, 32'h0);
        rst_n = 1'b1;

        // rd wr f3 addr sd rdata ready_at | fault data stall req baddr we wstrb wdata
        issue(1, 0, 3'b000, 32'h103, 32'h0, 32'h8000_0000, 1,
              mk(0, 32'hFFFF_FF80, 2, 1, 32'h100, 0, 4'b0000, 32'h0));
        issue(1, 0, 3'b101, 32'h202, 32'h0, 32'hBEEF_1234, 3,
              mk(0, 32'h0000_BEEF, 4, 3, 32'h200, 0, 4'b0000, 32'h0));
        issue(0, 1, 3'b000, 32'h301, 32'h0000_00A5, 32'h0, 1,
              mk(0, 32'h0000_BEEF, 2, 1, 32'h300, 1, 4'b0010, 32'hA5A5_A5A5));
        issue(1, 0, 3'b010, 32'h402, 32'h0, 32'h0, 1,
              mk(1, 32'h0, 1, 0, 32'h0, 0, 4'b0000, 32'h0));
        issue(1, 0, 3'b010, 32'h500, 32'h0, 32'h1234_5678, 16,
              mk(0, 32'h1234_5678, 17, 16, 32'h500, 0, 4'b0000, 32'h0));
        issue(1, 0, 3'b001, 32'h502, 32'h0, 32'h8001_0000, 2,
              mk(0, 32'hFFFF_8001, 3, 2, 32'h500, 0, 4'b0000, 32'h0));
        issue(1, 0, 3'b000, 32'h500, 32'h0, 32'h0000_007F, 1,
              mk(0, 32'h0000_007F, 2, 1, 32'h500, 0, 4'b0000, 32'h0));
        issue(1, 0, 3'b100, 32'h502, 32'h0, 32'h00FF_0000, 1,
              mk(0, 32'h0000_00FF, 2, 1, 32'h500, 0, 4'b0000, 32'h0));
        issue(1, 0, 3'b010, 32'h500, 32'h0, 32'h1111_1111, 0,
              mk(1, 32'h0, 17, 16, 32'h500, 0, 4'b0000, 32'h0));
        issue(1, 1, 3'b010, 32'h900, 32'h0, 32'h0, 1,
              mk(1, 32'h0, 1, 0, 32'h0, 0, 4'b0000, 32'h0));
        issue(0, 1, 3'b001, 32'h706, 32'h1234_ABCD, 32'h0, 2,
              mk(0, 32'h0, 3, 2, 32'h704, 1, 4'b1100, 32'hABCD_ABCD));
        issue(0, 1, 3'b010, 32'h800, 32'hDEAD_BEEF, 32'h0, 1,
              mk(0, 32'h0, 2, 1, 32'h800, 1, 4'b1111, 32'hDEAD_BEEF));
        issue(1, 0, 3'b000, 32'h501, 32'h0, 32'h0000_4200, 1,
              mk(0, 32'h0000_0042, 2, 1, 32'h500, 0, 4'b0000, 32'h0));
        issue(0, 1, 3'b100, 32'hA00, 32'h0, 32'h0, 1,
              mk(1, 32'h0000_0042, 1, 0, 32'h0, 0, 4'b0000, 32'h0));
        issue(0, 1, 3'b001, 32'h301, 32'h0, 32'h0, 1,
              mk(1, 32'h0000_0042, 1, 0, 32'h0, 0, 4'b0000, 32'h0));
        issue(1, 0, 3'b011, 32'hB00, 32'h0, 32'h0, 1,
              mk(1, 32'h0, 1, 0, 32'h0, 0, 4'b0000, 32'h0));

        // Asynchronous reset in the middle of a WAIT
        @(posedge clk); #1;
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h600; ready_at = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_bus_req", 32'(bus_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_bus_req", 32'(bus_req), 32'd0);
        chk("async_rst_stall", 32'(stall), 32'd0);
        chk("async_rst_fault", 32'(fault), 32'd0);
        mem_read = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        issue(1, 0, 3'b010, 32'h600, 32'h0, 32'hCAFE_F00D, 1,
              mk(0, 32'hCAFE_F00D, 2, 1, 32'h600, 0, 4'b0000, 32'h0));

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
